// File: rtl/ula_pkg.sv
// Shared definitions for the sliced 74181-style ALU: slice width, function
// codes as {m, s}, FSM states and the slice-count helper.
package ula_pkg;

  localparam int SLICE_W = 4;

  typedef logic [4:0] ula_func_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ula_state_t;

  // Arithmetic (m = 0); every result also adds c_in.
  localparam ula_func_t ULA_ARI_A              = 5'b0_0000;
  localparam ula_func_t ULA_ARI_A_OU_B         = 5'b0_0001;
  localparam ula_func_t ULA_ARI_A_OU_NB        = 5'b0_0010;
  localparam ula_func_t ULA_ARI_MENOS_UM       = 5'b0_0011;
  localparam ula_func_t ULA_ARI_A_MAIS_ANB     = 5'b0_0100;
  localparam ula_func_t ULA_ARI_AOB_MAIS_ANB   = 5'b0_0101;
  localparam ula_func_t ULA_ARI_SUB_MENOS_UM   = 5'b0_0110;
  localparam ula_func_t ULA_ARI_ANB_MENOS_UM   = 5'b0_0111;
  localparam ula_func_t ULA_ARI_A_MAIS_AB      = 5'b0_1000;
  localparam ula_func_t ULA_ARI_SOMA           = 5'b0_1001;
  localparam ula_func_t ULA_ARI_AONB_MAIS_AB   = 5'b0_1010;
  localparam ula_func_t ULA_ARI_AB_MENOS_UM    = 5'b0_1011;
  localparam ula_func_t ULA_ARI_DOBRO          = 5'b0_1100;
  localparam ula_func_t ULA_ARI_AOB_MAIS_A     = 5'b0_1101;
  localparam ula_func_t ULA_ARI_AONB_MAIS_A    = 5'b0_1110;
  localparam ula_func_t ULA_ARI_DECR           = 5'b0_1111;

  // Logic (m = 1).
  localparam ula_func_t ULA_LOG_NAO_A          = 5'b1_0000;
  localparam ula_func_t ULA_LOG_NOR            = 5'b1_0001;
  localparam ula_func_t ULA_LOG_NA_E_B         = 5'b1_0010;
  localparam ula_func_t ULA_LOG_ZERO           = 5'b1_0011;
  localparam ula_func_t ULA_LOG_NAND           = 5'b1_0100;
  localparam ula_func_t ULA_LOG_NAO_B          = 5'b1_0101;
  localparam ula_func_t ULA_LOG_XOR            = 5'b1_0110;
  localparam ula_func_t ULA_LOG_A_E_NB         = 5'b1_0111;
  localparam ula_func_t ULA_LOG_NA_OU_B        = 5'b1_1000;
  localparam ula_func_t ULA_LOG_XNOR           = 5'b1_1001;
  localparam ula_func_t ULA_LOG_B              = 5'b1_1010;
  localparam ula_func_t ULA_LOG_AND            = 5'b1_1011;
  localparam ula_func_t ULA_LOG_UM             = 5'b1_1100;
  localparam ula_func_t ULA_LOG_A_OU_NB        = 5'b1_1101;
  localparam ula_func_t ULA_LOG_OR             = 5'b1_1110;
  localparam ula_func_t ULA_LOG_A              = 5'b1_1111;

  function automatic int nslices(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/ula_fatia_181.sv
// One combinational 4-bit 74181-equivalent slice, active-high data and carry.
// Active-high group propagate/generate; all carry outputs are 0 in logic mode.
module ula_fatia_181
  import ula_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [3:0] f,
  output logic       c_out,
  output logic       p,
  output logic       g
);

  logic [3:0] t1;
  logic [3:0] t2;
  logic [3:0] f_ari;
  logic       cy;
  logic       gen;
  ula_func_t  func;

  always_comb begin
    // Arithmetic result is t1 + t2 + c_in; t2 is always a subset of t1,
    // so t1 acts as the bit propagate and t2 as the bit generate.
    t1    = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    t2    = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    cy    = c_in;
    gen   = 1'b0;
    f_ari = 4'h0;
    for (int i = 0; i < 4; i++) begin
      f_ari[i] = t1[i] ^ t2[i] ^ cy;
      cy       = t2[i] | (t1[i] & cy);
      gen      = t2[i] | (t1[i] & gen);
    end

    func = {m, s};
    f    = f_ari;
    case (func)
      ULA_LOG_NAO_A:   f = ~a;
      ULA_LOG_NOR:     f = ~(a | b);
      ULA_LOG_NA_E_B:  f = ~a & b;
      ULA_LOG_ZERO:    f = 4'h0;
      ULA_LOG_NAND:    f = ~(a & b);
      ULA_LOG_NAO_B:   f = ~b;
      ULA_LOG_XOR:     f = a ^ b;
      ULA_LOG_A_E_NB:  f = a & ~b;
      ULA_LOG_NA_OU_B: f = ~a | b;
      ULA_LOG_XNOR:    f = ~(a ^ b);
      ULA_LOG_B:       f = b;
      ULA_LOG_AND:     f = a & b;
      ULA_LOG_UM:      f = 4'hF;
      ULA_LOG_A_OU_NB: f = a | ~b;
      ULA_LOG_OR:      f = a | b;
      ULA_LOG_A:       f = a;
      default:         f = f_ari;
    endcase

    c_out = ~m & cy;
    p     = ~m & (&t1);
    g     = ~m & gen;
  end

endmodule

// File: rtl/ula_fatiada.sv
// Multi-cycle WIDTH-bit ALU built from chained 4-bit 74181 slices, evaluating
// SLICES_PER_CYCLE slices per clock behind valid/ready request/result ports.
module ula_fatiada
  import ula_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int SLICES_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             a_eq_b,
  output logic             p,
  output logic             g,
  output ula_state_t       dbg_state
);

  // Handshake: a request transfers on a rising edge where in_valid and
  // in_ready are both 1; a result transfers on an edge where out_valid and
  // out_ready are both 1. Result outputs are stable while out_valid is high.

  localparam int NSLICES = nslices(WIDTH);
  localparam int STEPS   = NSLICES / SLICES_PER_CYCLE;
  localparam int CHUNK   = SLICES_PER_CYCLE * SLICE_W;
  localparam int IDX_W   = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

  ula_state_t       state_q;
  logic [WIDTH-1:0] a_q, b_q, shadow_q, f_q;
  logic [3:0]       s_q;
  logic             m_q, carry_q, p_acc_q, g_acc_q;
  logic [IDX_W-1:0] idx_q;
  logic             c_out_q, a_eq_b_q, p_q, g_q, out_valid_q, in_ready_q;

  logic [CHUNK-1:0]            chunk_f;
  logic [SLICES_PER_CYCLE-1:0] sp, sg;
  logic                        carry_d, p_acc_d, g_acc_d;
  logic [WIDTH-1:0]            shadow_d;

  // Operands shift right each step, so the slices always see the low chunk.
  for (genvar j = 0; j < SLICES_PER_CYCLE; j++) begin : g_fatia
    logic       cin_w, cout_w, p_w, g_w;
    logic [3:0] f_w;
    if (j == 0) begin : g_first
      assign cin_w = carry_q;
    end else begin : g_next
      assign cin_w = g_fatia[j-1].cout_w;
    end
    ula_fatia_181 u_fatia (
      .a     (a_q[j*SLICE_W +: SLICE_W]),
      .b     (b_q[j*SLICE_W +: SLICE_W]),
      .s     (s_q),
      .m     (m_q),
      .c_in  (cin_w),
      .f     (f_w),
      .c_out (cout_w),
      .p     (p_w),
      .g     (g_w)
    );
    assign chunk_f[j*SLICE_W +: SLICE_W] = f_w;
    assign sp[j] = p_w;
    assign sg[j] = g_w;
  end

  assign carry_d = g_fatia[SLICES_PER_CYCLE-1].cout_w;

  always_comb begin
    p_acc_d = p_acc_q;
    g_acc_d = g_acc_q;
    for (int j = 0; j < SLICES_PER_CYCLE; j++) begin
      g_acc_d = sg[j] | (sp[j] & g_acc_d);
      p_acc_d = p_acc_d & sp[j];
    end
    // Result nibbles enter from the top, so after STEPS shifts they are in place.
    shadow_d = (shadow_q >> CHUNK) | (WIDTH'(chunk_f) << (WIDTH - CHUNK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= 4'h0;
      m_q         <= 1'b0;
      carry_q     <= 1'b0;
      p_acc_q     <= 1'b0;
      g_acc_q     <= 1'b0;
      idx_q       <= '0;
      shadow_q    <= '0;
      f_q         <= '0;
      c_out_q     <= 1'b0;
      a_eq_b_q    <= 1'b0;
      p_q         <= 1'b0;
      g_q         <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            s_q        <= s;
            m_q        <= m;
            carry_q    <= c_in;
            p_acc_q    <= 1'b1;
            g_acc_q    <= 1'b0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          a_q      <= a_q >> CHUNK;
          b_q      <= b_q >> CHUNK;
          shadow_q <= shadow_d;
          carry_q  <= carry_d;
          p_acc_q  <= p_acc_d;
          g_acc_q  <= g_acc_d;
          idx_q    <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            f_q         <= shadow_d;
            c_out_q     <= carry_d;
            p_q         <= p_acc_d;
            g_q         <= g_acc_d;
            a_eq_b_q    <= &shadow_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign c_out     = c_out_q;
  assign a_eq_b    = a_eq_b_q;
  assign p         = p_q;
  assign g         = g_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ula_fatiada.sv
// Bench for ula_fatiada: three configurations share one request bus; a
// datasheet-table reference model feeds per-instance expected queues.
module tb_ula_fatiada;
  import ula_pkg::*;

  localparam int STEPS0 = 4;  // WIDTH 16, 1 slice/cycle
  localparam int STEPS1 = 1;  // WIDTH 16, 4 slices/cycle
  localparam int STEPS2 = 4;  // WIDTH 32, 2 slices/cycle

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a_b = '0, b_b = '0;
  logic [3:0]  s_b = '0;
  logic        m_b = 1'b0, c_b = 1'b0;
  logic [2:0]  ir, ov, co, ae, pp, gg;
  logic [15:0] f0, f1;
  logic [31:0] f2;
  ula_state_t  st0, st1, st2;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic rdy_force = 1'b1;
  logic rdy_val   = 1'b0;

  logic [67:0] exp_q[3][$];
  logic        seen[3];
  logic [35:0] held[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #2;
    out_ready = rdy_force ? rdy_val : 1'($urandom_range(0, 1));
  end

  ula_fatiada #(.WIDTH(16), .SLICES_PER_CYCLE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a_b[15:0]), .b(b_b[15:0]), .s(s_b), .m(m_b), .c_in(c_b),
    .out_valid(ov[0]), .out_ready(out_ready), .f(f0), .c_out(co[0]),
    .a_eq_b(ae[0]), .p(pp[0]), .g(gg[0]), .dbg_state(st0));

  ula_fatiada #(.WIDTH(16), .SLICES_PER_CYCLE(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a_b[15:0]), .b(b_b[15:0]), .s(s_b), .m(m_b), .c_in(c_b),
    .out_valid(ov[1]), .out_ready(out_ready), .f(f1), .c_out(co[1]),
    .a_eq_b(ae[1]), .p(pp[1]), .g(gg[1]), .dbg_state(st1));

  ula_fatiada #(.WIDTH(32), .SLICES_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a_b), .b(b_b), .s(s_b), .m(m_b), .c_in(c_b),
    .out_valid(ov[2]), .out_ready(out_ready), .f(f2), .c_out(co[2]),
    .a_eq_b(ae[2]), .p(pp[2]), .g(gg[2]), .dbg_state(st2));

  // Reference: returns {g, p, a_eq_b, c_out, f[31:0]} for a w-bit ALU.
  function automatic logic [35:0] ula_ref(input logic [31:0] av, bv,
                                          input logic [3:0] sv,
                                          input logic mv, cv, input int w);
    logic [32:0] mask, aa, bb, na, nb, x, y, sum, xy;
    logic [31:0] fr;
    logic        co_r, pr, gr, aeq;
    mask = (33'd1 << w) - 33'd1;
    aa = {1'b0, av} & mask;
    bb = {1'b0, bv} & mask;
    na = ~aa & mask;
    nb = ~bb & mask;
    x = '0; y = '0;
    co_r = 1'b0; pr = 1'b0; gr = 1'b0;
    if (mv) begin
      case (sv)
        4'd0:  x = na;
        4'd1:  x = ~(aa | bb) & mask;
        4'd2:  x = na & bb;
        4'd3:  x = '0;
        4'd4:  x = ~(aa & bb) & mask;
        4'd5:  x = nb;
        4'd6:  x = aa ^ bb;
        4'd7:  x = aa & nb;
        4'd8:  x = na | bb;
        4'd9:  x = ~(aa ^ bb) & mask;
        4'd10: x = bb;
        4'd11: x = aa & bb;
        4'd12: x = mask;
        4'd13: x = aa | nb;
        4'd14: x = aa | bb;
        default: x = aa;
      endcase
      fr = x[31:0];
    end else begin
      // Datasheet entries as "first term plus second term plus Cin".
      case (sv)
        4'd0:  begin x = aa;      y = '0;      end
        4'd1:  begin x = aa | bb; y = '0;      end
        4'd2:  begin x = aa | nb; y = '0;      end
        4'd3:  begin x = mask;    y = '0;      end
        4'd4:  begin x = aa;      y = aa & nb; end
        4'd5:  begin x = aa | bb; y = aa & nb; end
        4'd6:  begin x = aa | nb; y = aa & nb; end
        4'd7:  begin x = mask;    y = aa & nb; end
        4'd8:  begin x = aa;      y = aa & bb; end
        4'd9:  begin x = aa | bb; y = aa & bb; end
        4'd10: begin x = aa | nb; y = aa & bb; end
        4'd11: begin x = mask;    y = aa & bb; end
        4'd12: begin x = aa;      y = aa;      end
        4'd13: begin x = aa | bb; y = aa;      end
        4'd14: begin x = aa | nb; y = aa;      end
        default: begin x = mask;  y = aa;      end
      endcase
      sum  = x + y + 33'(cv);
      xy   = x + y;
      fr   = sum[31:0] & mask[31:0];
      co_r = sum[w];
      gr   = xy[w];
      pr   = (x == mask);
    end
    aeq = (fr == mask[31:0]);
    return {gr, pr, aeq, co_r, fr};
  endfunction

  task automatic chk(input string name, input int d, input logic [35:0] got, want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s dut%0d got %h want %h (t=%0t)", name, d, got, want, $time);
    end
  endtask

  task automatic mon_step(input int d, input logic ovv, input logic [31:0] fv,
                          input logic cov, aev, pv, gv, input int steps);
    logic [35:0] act;
    logic [67:0] e;
    int lat;
    act = {gv, pv, aev, cov, fv};
    if (!ovv) begin
      seen[d] = 1'b0;
    end else if (!seen[d]) begin
      seen[d] = 1'b1;
      held[d] = act;
      if (exp_q[d].size() == 0) begin
        chk("spurious_result", d, 36'(exp_q[d].size()), 36'd1);
      end else begin
        e = exp_q[d].pop_front();
        lat = cyc - int'(e[67:36]);
        chk("result", d, act, e[35:0]);
        chk("latency", d, 36'(lat), 36'(steps));
      end
    end else begin
      chk("hold_stable", d, act, held[d]);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_step(0, ov[0], {16'h0, f0}, co[0], ae[0], pp[0], gg[0], STEPS0);
      mon_step(1, ov[1], {16'h0, f1}, co[1], ae[1], pp[1], gg[1], STEPS1);
      mon_step(2, ov[2], f2,          co[2], ae[2], pp[2], gg[2], STEPS2);
    end
  end

  task automatic issue(input logic [31:0] av, bv, input logic [3:0] sv,
                       input logic mv, cv);
    int w;
    int acc;
    w = 0;
    @(negedge clk);
    while (ir != 3'b111 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("issue_ready", 0, 36'(ir), 36'h7);
    if (ir == 3'b111) begin
      a_b = av; b_b = bv; s_b = sv; m_b = mv; c_b = cv;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      in_valid = 1'b0;
      exp_q[0].push_back({32'(acc), ula_ref(av & 32'hFFFF, bv & 32'hFFFF, sv, mv, cv, 16)});
      exp_q[1].push_back({32'(acc), ula_ref(av & 32'hFFFF, bv & 32'hFFFF, sv, mv, cv, 16)});
      exp_q[2].push_back({32'(acc), ula_ref(av, bv, sv, mv, cv, 32)});
    end
  endtask

  task automatic chk_reset;
    chk("rst_f", 0, 36'(f0), 36'd0);
    chk("rst_f", 1, 36'(f1), 36'd0);
    chk("rst_f", 2, 36'(f2), 36'd0);
    for (int d = 0; d < 3; d++)
      chk("rst_flags", d, 36'({ov[d], ir[d], co[d], ae[d], pp[d], gg[d]}), 36'd0);
  endtask

  task automatic wait_idle;
    int w;
    w = 0;
    while (ir != 3'b111 && w < 200) begin
      @(negedge clk);
      w++;
    end
  endtask

  initial begin
    int w;
    for (int d = 0; d < 3; d++) seen[d] = 1'b0;

    // Reset with in_valid already high: nothing may be accepted.
    in_valid = 1'b1;
    a_b = 32'h0000_1111; b_b = 32'h0000_2222; s_b = 4'b1001;
    repeat (3) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int d = 0; d < 3; d++) chk("ready_after_rst", d, 36'(ir[d]), 36'd1);
    repeat (4) @(negedge clk);
    for (int d = 0; d < 3; d++) chk("no_accept_in_rst", d, 36'(ov[d]), 36'd0);

    // Directed vectors.
    rdy_force = 1'b1; rdy_val = 1'b1;
    issue(32'h0000_1234, 32'h0000_0FCD, 4'b1001, 1'b0, 1'b0);
    issue(32'hFFFF_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0);
    issue(32'h5A5A_5A5A, 32'h5A5A_5A5A, 4'b0110, 1'b0, 1'b0);
    issue(32'h5A5A_5A5A, 32'h5A5A_5A5A, 4'b0110, 1'b0, 1'b1);
    issue(32'h0000_FFFF, 32'hFFFF_0001, 4'b1111, 1'b0, 1'b1);

    // Result held while out_ready stays low; further requests ignored.
    wait_idle();
    rdy_val = 1'b0;
    issue(32'hA5A5_A5A5, 32'h0FF0_0FF0, 4'b0110, 1'b1, 1'b0);
    w = 0;
    while (ov != 3'b111 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("hold_reach_done", 0, 36'(ov), 36'h7);
    repeat (10) begin
      @(negedge clk);
      a_b = $urandom; b_b = $urandom; s_b = 4'($urandom_range(0, 15));
      in_valid = 1'b1;
      for (int d = 0; d < 3; d++) begin
        chk("hold_valid", d, 36'(ov[d]), 36'd1);
        chk("hold_ready", d, 36'(ir[d]), 36'd0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    rdy_val = 1'b1;
    repeat (8) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("no_second_valid", d, 36'(ov[d]), 36'd0);
      chk("no_second_queue", d, 36'(exp_q[d].size()), 36'd0);
    end

    // Reset in the second BUSY cycle drops the operation.
    wait_idle();
    rdy_val = 1'b0;
    issue($urandom, $urandom, 4'b1001, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset();
    for (int d = 0; d < 3; d++) begin
      exp_q[d].delete();
      seen[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) chk("ready_low_at_release", d, 36'(ir[d]), 36'd0);
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk("ready_rise_after_rst", d, 36'(ir[d]), 36'd1);
    rdy_val = 1'b1;
    issue($urandom, $urandom, 4'b1001, 1'b0, 1'($urandom_range(0, 1)));

    // Randomized operations with random back-pressure.
    rdy_force = 1'b0;
    repeat (60) begin
      issue($urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    rdy_force = 1'b1;
    rdy_val = 1'b1;
    w = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain", 0, 36'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 36'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
